bin_averager: RTL and testbench

- Downstream neighbour of the bin collection stage.
- Consumes one frame of BINS collected bin words per input strobe.
- Accumulates 2^N_AVGS consecutive frames per bin in wide accumulators.
- Emits one frame of per-bin averages, with a one-cycle valid strobe, to the packetiser/Ethernet stage.

---
 rtl/bin_averager.sv | 108 ++++++++++
 tb/tb_bin_averager.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_averager.sv
// bin_averager: accumulates 2^N_AVGS frames of BINS unsigned bin words and
// emits the per-bin floor average as a frame marked by a one-cycle strobe.
module bin_averager #(
  parameter int N         = 16,
  parameter int N_AVGS    = 7,
  parameter int SUM_WIDTH = 128,
  parameter int BINS      = 4
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [BINS-1:0][N-1:0] in_data,
  output logic [BINS-1:0][N-1:0] out_data,
  output logic                   out_valid,
  output logic [N_AVGS:0]        frame_cnt,
  output logic                   busy
);

  // Accumulators only need N+N_AVGS bits; the bits above that are always zero.
  localparam int ACC_W = N + N_AVGS;
  localparam logic [N_AVGS:0] LAST_CNT = (N_AVGS+1)'((1 << N_AVGS) - 1);

  if (SUM_WIDTH < N + N_AVGS) begin : g_sum_width_check
    $error("bin_averager: SUM_WIDTH (%0d) must be >= N+N_AVGS (%0d)", SUM_WIDTH, N + N_AVGS);
  end
  if (N_AVGS < 0 || N_AVGS > 16) begin : g_navgs_check
    $error("bin_averager: N_AVGS (%0d) must be in 0..16", N_AVGS);
  end

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ACCUM = 3'b010,
    DUMP  = 3'b100
  } state_t;

  state_t                     state, state_next;
  logic [BINS-1:0][ACC_W-1:0] acc, acc_next, acc_base, sum;
  logic [N_AVGS:0]            cnt_base, cnt_next;
  logic [BINS-1:0][N-1:0]     out_next;
  logic                       dump_next;

  // Outside ACCUM a frame always starts a fresh average, so the base is zero.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = frame_cnt;
    out_next   = out_data;
    dump_next  = 1'b0;
    acc_base   = (state == ACCUM) ? acc : '0;
    cnt_base   = (state == ACCUM) ? frame_cnt : '0;
    sum        = '0;
    for (int b = 0; b < BINS; b++) begin
      sum[b] = acc_base[b] + ACC_W'(in_data[b]);
    end

    case (state)
      ACCUM: state_next = ACCUM;
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
      end
    endcase

    if (in_valid) begin
      if (cnt_base == LAST_CNT) begin
        state_next = DUMP;
        dump_next  = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
        for (int b = 0; b < BINS; b++) begin
          out_next[b] = sum[b][ACC_W-1:N_AVGS];
        end
      end else begin
        state_next = ACCUM;
        acc_next   = sum;
        cnt_next   = cnt_base + (N_AVGS+1)'(1);
      end
    end
  end

  // The average is registered on the edge that takes the final frame, so
  // out_data and out_valid are both new during the DUMP cycle.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state     <= IDLE;
      acc       <= '0;
      frame_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      frame_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      frame_cnt <= cnt_next;
      out_data  <= out_next;
      out_valid <= dump_next;
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_bin_averager.sv
// tb_bin_averager: directed, table-driven bench for bin_averager at default
// parameters plus a second instance with N_AVGS=0.
module tb_bin_averager;

  typedef enum int {K_CONST, K_RAMP, K_ALT} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [63:0] base;
    int          gap;
    logic [63:0] exp_data;
  } avg_vec_t;

  typedef struct packed {
    logic [63:0] in_frame;
    logic [63:0] exp_frame;
  } pass_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  areset_n;
  logic                  clear;
  logic                  in_valid;
  logic [3:0][15:0]      in_data;
  logic [3:0][15:0]      out_data;
  logic                  out_valid;
  logic [7:0]            frame_cnt;
  logic                  busy;

  logic                  in_valid1;
  logic [3:0][15:0]      in_data1;
  logic [3:0][15:0]      out_data1;
  logic                  out_valid1;
  logic [0:0]            frame_cnt1;
  logic                  busy1;

  bin_averager dut0 (
    .clk       (clk),
    .areset_n  (areset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  bin_averager #(.N_AVGS(0)) dut1 (
    .clk       (clk),
    .areset_n  (areset_n),
    .clear     (clear),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .out_data  (out_data1),
    .out_valid (out_valid1),
    .frame_cnt (frame_cnt1),
    .busy      (busy1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          pulses   = 0;
  logic [63:0] pulse_data[$];
  int          pulse_cycle[$];

  // Every out_valid strobe of the averaging instance is logged mid-cycle.
  always @(negedge clk) begin
    cycle++;
    if (out_valid) begin
      pulses++;
      pulse_data.push_back(out_data);
      pulse_cycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic [63:0] data, input logic clr);
    if (sel == 0) begin
      in_valid = valid;
      in_data  = data;
    end else begin
      in_valid1 = valid;
      in_data1  = data;
    end
    clear = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    clear     = 1'b0;
  endtask

  function automatic logic [63:0] frameVal(input avg_vec_t v, input int k);
    case (v.kind)
      K_RAMP:  return {4{16'(k)}};
      K_ALT:   return {4{16'(k % 2)}};
      default: return v.base;
    endcase
  endfunction

  // Sends 128 frames and checks the strobe lands exactly one cycle after the last.
  task automatic runAverage(input avg_vec_t v, input string tag);
    int p0;
    p0 = pulses;
    for (int k = 0; k < 128; k++) begin
      applyStimulus(0, 1'b1, frameVal(v, k), 1'b0);
      if (k == 126) begin
        checkOutput({tag, " cnt127"}, frame_cnt, 64'd127);
        checkOutput({tag, " busy127"}, busy, 64'd1);
        checkOutput({tag, " early valid"}, out_valid, 64'd0);
      end
      if (k == 127) begin
        checkOutput({tag, " valid"}, out_valid, 64'd1);
        checkOutput({tag, " data"}, out_data, v.exp_data);
        checkOutput({tag, " cnt after"}, frame_cnt, 64'd0);
        checkOutput({tag, " busy after"}, busy, 64'd0);
      end
      for (int g = 1; g < v.gap; g++) applyStimulus(0, 1'b0, 64'd0, 1'b0);
    end
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    checkOutput({tag, " valid drop"}, out_valid, 64'd0);
    checkOutput({tag, " data held"}, out_data, v.exp_data);
    checkOutput({tag, " pulses"}, 64'(pulses - p0), 64'd1);
  endtask

  avg_vec_t  avg_tab[5];
  pass_vec_t pass_tab[4];

  initial begin
    int       p0;
    int       s0;
    avg_vec_t v;

    avg_tab[0] = '{K_CONST, {4{16'h1234}}, 3, {4{16'h1234}}};
    avg_tab[1] = '{K_RAMP,  64'd0,         1, {4{16'h003F}}};
    avg_tab[2] = '{K_ALT,   64'd0,         2, {4{16'h0000}}};
    avg_tab[3] = '{K_CONST, {4{16'hFFFF}}, 1, {4{16'hFFFF}}};
    avg_tab[4] = '{K_CONST, {16'h7FFF, 16'hABCD, 16'h8000, 16'h0001}, 1,
                            {16'h7FFF, 16'hABCD, 16'h8000, 16'h0001}};

    pass_tab[0] = '{{16'h0001, 16'h0002, 16'h0003, 16'h0004}, {16'h0001, 16'h0002, 16'h0003, 16'h0004}};
    pass_tab[1] = '{{16'hBEEF, 16'h0000, 16'hFFFF, 16'h8001}, {16'hBEEF, 16'h0000, 16'hFFFF, 16'h8001}};
    pass_tab[2] = '{{4{16'h5A5A}},                            {4{16'h5A5A}}};
    pass_tab[3] = '{{16'hFFFF, 16'h1234, 16'h00FF, 16'hC0DE}, {16'hFFFF, 16'h1234, 16'h00FF, 16'hC0DE}};

    areset_n  = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    checkOutput("reset out_data", out_data, 64'd0);
    checkOutput("reset out_valid", out_valid, 64'd0);
    checkOutput("reset frame_cnt", frame_cnt, 64'd0);
    checkOutput("reset busy", busy, 64'd0);
    areset_n = 1'b1;
    applyStimulus(0, 1'b0, 64'd0, 1'b0);

    $display("[TB] averaging table");
    for (int i = 0; i < 5; i++) begin
      runAverage(avg_tab[i], $sformatf("avg%0d", i));
    end

    $display("[TB] back-to-back frames");
    p0 = pulses;
    s0 = pulse_data.size();
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1'b1, (k < 128) ? {4{16'h0010}} : {4{16'h0020}}, 1'b0);
      if (k == 127) begin
        checkOutput("b2b dump valid", out_valid, 64'd1);
        checkOutput("b2b dump cnt", frame_cnt, 64'd0);
      end
      if (k == 128) begin
        checkOutput("b2b reload valid", out_valid, 64'd0);
        checkOutput("b2b reload cnt", frame_cnt, 64'd1);
        checkOutput("b2b reload busy", busy, 64'd1);
      end
    end
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    checkOutput("b2b pulses", 64'(pulses - p0), 64'd2);
    if (pulse_data.size() >= s0 + 2) begin
      checkOutput("b2b first", pulse_data[s0], {4{16'h0010}});
      checkOutput("b2b second", pulse_data[s0+1], {4{16'h0020}});
      checkOutput("b2b spacing", 64'(pulse_cycle[s0+1] - pulse_cycle[s0]), 64'd128);
    end

    $display("[TB] clear sequences");
    for (int k = 0; k < 50; k++) applyStimulus(0, 1'b1, {4{16'h1000}}, 1'b0);
    checkOutput("clr cnt50", frame_cnt, 64'd50);
    applyStimulus(0, 1'b0, 64'd0, 1'b1);
    checkOutput("clr cnt", frame_cnt, 64'd0);
    checkOutput("clr busy", busy, 64'd0);
    checkOutput("clr valid", out_valid, 64'd0);
    checkOutput("clr data held", out_data, {4{16'h0020}});
    v = '{K_CONST, {4{16'h0002}}, 1, {4{16'h0002}}};
    runAverage(v, "clr avg");
    for (int k = 0; k < 5; k++) applyStimulus(0, 1'b1, {4{16'h0100}}, 1'b0);
    checkOutput("clr5 cnt", frame_cnt, 64'd5);
    applyStimulus(0, 1'b1, {4{16'h0100}}, 1'b1);
    checkOutput("clr+valid accum cnt", frame_cnt, 64'd0);
    checkOutput("clr+valid accum busy", busy, 64'd0);
    applyStimulus(0, 1'b1, {4{16'h0100}}, 1'b1);
    checkOutput("clr+valid idle cnt", frame_cnt, 64'd0);
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    checkOutput("clr idle hold cnt", frame_cnt, 64'd0);
    applyStimulus(0, 1'b1, {4{16'h0055}}, 1'b0);
    checkOutput("post clr load cnt", frame_cnt, 64'd1);

    $display("[TB] reset mid-accumulation");
    for (int k = 1; k < 100; k++) applyStimulus(0, 1'b1, {4{16'h0055}}, 1'b0);
    checkOutput("rst cnt100", frame_cnt, 64'd100);
    areset_n = 1'b0;
    applyStimulus(0, 1'b0, 64'd0, 1'b0);
    areset_n = 1'b1;
    checkOutput("rst mid data", out_data, 64'd0);
    checkOutput("rst mid valid", out_valid, 64'd0);
    checkOutput("rst mid cnt", frame_cnt, 64'd0);
    checkOutput("rst mid busy", busy, 64'd0);
    v = '{K_CONST, {4{16'h00AA}}, 1, {4{16'h00AA}}};
    runAverage(v, "rst avg");

    $display("[TB] N_AVGS=0 instance");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, pass_tab[i].in_frame, 1'b0);
      checkOutput($sformatf("pass%0d valid", i), out_valid1, 64'd1);
      checkOutput($sformatf("pass%0d data", i), out_data1, pass_tab[i].exp_frame);
      checkOutput($sformatf("pass%0d cnt", i), frame_cnt1, 64'd0);
      applyStimulus(1, 1'b0, 64'd0, 1'b0);
      checkOutput($sformatf("pass%0d drop", i), out_valid1, 64'd0);
      checkOutput($sformatf("pass%0d hold", i), out_data1, pass_tab[i].exp_frame);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, pass_tab[i].in_frame, 1'b0);
      checkOutput($sformatf("stream%0d valid", i), out_valid1, 64'd1);
      checkOutput($sformatf("stream%0d data", i), out_data1, pass_tab[i].exp_frame);
    end
    applyStimulus(1, 1'b0, 64'd0, 1'b0);
    checkOutput("stream end valid", out_valid1, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
